// File: rtl/hip_adc_pkg.sv
// hip_adc_pkg: capture FSM states and shared constants for the ADC SPI front end
package hip_adc_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int MIN_DIV   = 2;
    localparam int OVF_CNT_W = 8;
endpackage

// File: rtl/hip_sync_fifo.sv
// hip_sync_fifo: show-ahead synchronous FIFO with occupancy output
module hip_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;
    assign valid   = level != '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/hip_adc_spi_capture.sv
// hip_adc_spi_capture: periodic SPI-master ADC capture into a show-ahead FIFO; define HIP_ADC_OVF_CNT_EN for the drop counter
module hip_adc_spi_capture
    import hip_adc_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          enable_i,
    input  logic [DIV_W-1:0]              clk_div_i,
    input  logic [15:0]                   period_i,
    output logic                          adc_sclk_o,
    output logic                          adc_cs_no,
    input  logic                          adc_miso_i,
    output logic [SAMPLE_BITS-1:0]        sample_data_o,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    input  logic                          clear_ovf_i,
    output logic [OVF_CNT_W-1:0]          ovf_count_o,
    output logic                          busy_o
);
    localparam int BW = $clog2(SAMPLE_BITS);
    state_t                 state;
    logic [DIV_W-1:0]       hm1, cnt;
    logic [BW-1:0]          bit_cnt;
    logic [15:0]            pcnt;
    logic [1:0]             miso_sync;
    logic [SAMPLE_BITS-1:0] shreg;
    logic                   pend, push, full, ovf_set, last, last_bit;
    assign hm1      = (clk_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div_i;
    assign last     = cnt == hm1;
    assign last_bit = bit_cnt == BW'(SAMPLE_BITS - 1);
    assign busy_o   = state != IDLE;
    assign ovf_set  = push && full && !(sample_ready_i && sample_valid_o);
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            pcnt       <= '0;
            pend       <= 1'b0;
            push       <= 1'b0;
            adc_sclk_o <= 1'b0;
            adc_cs_no  <= 1'b1;
            shreg      <= '0;
            miso_sync  <= '0;
        end else begin
            miso_sync <= {miso_sync[0], adc_miso_i};
            push      <= 1'b0;
            cnt       <= (last || state == IDLE) ? '0 : cnt + DIV_W'(1);
            pcnt      <= (!enable_i || pcnt == period_i) ? '0 : pcnt + 16'd1;
            // a fresh trigger wins over IDLE consuming the previous one
            pend      <= enable_i && (pcnt == period_i || (pend && state != IDLE));
            case (state)
                IDLE: if (pend) begin
                    state     <= SETUP;
                    adc_cs_no <= 1'b0;
                end
                SETUP: if (last) begin
                    state      <= SHIFT;
                    adc_sclk_o <= 1'b1;
                    bit_cnt    <= '0;
                end
                SHIFT: if (last) begin
                    adc_sclk_o <= !adc_sclk_o && !last_bit;
                    if (adc_sclk_o) shreg <= {shreg[SAMPLE_BITS-2:0], miso_sync[1]};
                    else if (last_bit) state <= HOLD;
                    else bit_cnt <= bit_cnt + BW'(1);
                end
                HOLD: if (last) begin
                    state     <= GAP;
                    adc_cs_no <= 1'b1;
                    push      <= 1'b1;
                end
                GAP: if (last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) overflow_o <= 1'b0;
        else overflow_o <= ovf_set || (overflow_o && !clear_ovf_i);
`ifdef HIP_ADC_OVF_CNT_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) ovf_count_o <= '0;
        else ovf_count_o <= ovf_set ? (clear_ovf_i ? OVF_CNT_W'(1) : ovf_count_o + OVF_CNT_W'(ovf_count_o != '1))
                                    : (clear_ovf_i ? '0 : ovf_count_o);
`else
    assign ovf_count_o = '0;
`endif
    hip_sync_fifo #(.WIDTH(SAMPLE_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (push),
        .pop   (sample_ready_i),
        .din   (shreg),
        .dout  (sample_data_o),
        .valid (sample_valid_o),
        .full  (full),
        .level (fifo_level_o)
    );
endmodule

// File: tb/tb_hip_adc_spi_capture.sv
// tb_hip_adc_spi_capture: directed bench for the ADC SPI capture block with a mode-0 ADC model
module tb_hip_adc_spi_capture;
    localparam int SB = 24;
`ifdef HIP_ADC_OVF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif
    logic          wb_clk_i = 0, wb_rst_ni = 0, enable_i = 0, adc_miso_i = 0, sample_ready_i = 0, clear_ovf_i = 0;
    logic [7:0]    clk_div_i = 8'd2;
    logic [15:0]   period_i = 16'd199;
    logic          adc_sclk_o, adc_cs_no, sample_valid_o, overflow_o, busy_o;
    logic [SB-1:0] sample_data_o;
    logic [3:0]    fifo_level_o;
    logic [7:0]    ovf_count_o;
    int            checks = 0, errors = 0;
    int            cs_low = 0, rises = 0, hi_run = 0, last_hi = 0, cs_falls = 0, idx = 0;
    logic          prev_cs = 1, prev_sclk = 0, in_frame = 0;
    logic [SB-1:0] tx_word = '0, cur = '0;
    int            drain_exp [8] = '{2, 3, 4, 5, 6, 7, 8, 11};
    typedef struct { logic [7:0] div; logic [SB-1:0] word; int h; int cs_len; } vec_t;
    vec_t vecs [5];

    hip_adc_spi_capture #(.SAMPLE_BITS(SB), .FIFO_DEPTH(8), .DIV_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .enable_i(enable_i), .clk_div_i(clk_div_i),
        .period_i(period_i), .adc_sclk_o(adc_sclk_o), .adc_cs_no(adc_cs_no), .adc_miso_i(adc_miso_i),
        .sample_data_o(sample_data_o), .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
        .fifo_level_o(fifo_level_o), .overflow_o(overflow_o), .clear_ovf_i(clear_ovf_i),
        .ovf_count_o(ovf_count_o), .busy_o(busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ADC model: MSB presented at CS fall, next bit after each SCLK fall
    always @(adc_cs_no or negedge adc_sclk_o) begin
        if (!adc_cs_no && !in_frame) begin
            idx = SB - 1;
            cur = tx_word;
        end else if (!adc_cs_no && idx > 0) idx--;
        in_frame   = !adc_cs_no;
        adc_miso_i = cur[idx];
    end

    always @(negedge wb_clk_i) begin
        if (!adc_cs_no && prev_cs) begin
            cs_low = 0;
            rises  = 0;
            cs_falls++;
        end
        if (!adc_cs_no) cs_low++;
        if (adc_sclk_o && !prev_sclk) rises++;
        if (adc_sclk_o) hi_run++;
        else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
        prev_cs   = adc_cs_no;
        prev_sclk = adc_sclk_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic wait_cs(input logic lvl, input string name);
        int n = 0;
        while (adc_cs_no !== lvl && n < 5000) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk(name, 32'(adc_cs_no), 32'(lvl));
    endtask

    task automatic wait_rises(input int k, input string name);
        int n = 0;
        while (!(rises >= k && adc_sclk_o) && n < 5000) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk(name, 32'(rises >= k), 1);
    endtask

    task automatic pop_one();
        sample_ready_i = 1;
        @(negedge wb_clk_i);
        sample_ready_i = 0;
    endtask

    task automatic run_frame(input logic [SB-1:0] w, input logic pop_at_push, input logic clr_at_push);
        tx_word  = w;
        enable_i = 1;
        wait_cs(0, "cs_fall");
        enable_i = 0;
        wait_cs(1, "cs_rise");
        sample_ready_i = pop_at_push;
        clear_ovf_i    = clr_at_push;
        @(negedge wb_clk_i);
        sample_ready_i = 0;
        clear_ovf_i    = 0;
        @(negedge wb_clk_i);
    endtask

    initial begin
        int falls;
        vecs = '{'{8'd2, 24'hA5C3F0, 3, 150}, '{8'd0, 24'hA5C3F0, 3, 150}, '{8'd1, 24'h800001, 3, 150},
                 '{8'd5, 24'hFFFFFF, 6, 300}, '{8'd3, 24'h13579B, 4, 200}};
        cycles(3);
        wb_rst_ni = 1;
        cycles(2);
        chk("rst_cs", 32'(adc_cs_no), 1);
        chk("rst_sclk", 32'(adc_sclk_o), 0);
        chk("rst_valid", 32'(sample_valid_o), 0);
        chk("rst_data", 32'(sample_data_o), 0);
        chk("rst_level", 32'(fifo_level_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_ovf_cnt", 32'(ovf_count_o), 0);
        chk("rst_busy", 32'(busy_o), 0);

        for (int i = 0; i < 5; i++) begin
            clk_div_i = vecs[i].div;
            run_frame(vecs[i].word, 0, 0);
            chk("sclk_rises", rises, SB);
            chk("cs_low_cycles", cs_low, vecs[i].cs_len);
            chk("sclk_high_phase", last_hi, vecs[i].h);
            chk("frame_data", 32'(sample_data_o), 32'(vecs[i].word));
            chk("level_one", 32'(fifo_level_o), 1);
            pop_one();
            chk("level_after_pop", 32'(fifo_level_o), 0);
        end

        clk_div_i = 8'd2;
        for (int i = 1; i <= 10; i++) run_frame(SB'(i), 0, 0);
        chk("ovf_level", 32'(fifo_level_o), 8);
        chk("ovf_flag", 32'(overflow_o), 1);
        chk("ovf_count", 32'(ovf_count_o), CNT_ON ? 2 : 0);
        chk("ovf_head", 32'(sample_data_o), 1);
        clear_ovf_i = 1;
        @(negedge wb_clk_i);
        clear_ovf_i = 0;
        chk("clr_flag", 32'(overflow_o), 0);
        chk("clr_count", 32'(ovf_count_o), 0);

        run_frame(24'd11, 1, 0);
        chk("full_pp_level", 32'(fifo_level_o), 8);
        chk("full_pp_ovf", 32'(overflow_o), 0);
        chk("full_pp_head", 32'(sample_data_o), 2);
        run_frame(24'd12, 0, 0);
        chk("drop_flag", 32'(overflow_o), 1);
        chk("drop_count", 32'(ovf_count_o), CNT_ON ? 1 : 0);
        run_frame(24'd13, 0, 1);
        chk("set_wins_flag", 32'(overflow_o), 1);
        chk("set_wins_count", 32'(ovf_count_o), CNT_ON ? 1 : 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(sample_data_o), drain_exp[i]);
            pop_one();
        end
        chk("drained_valid", 32'(sample_valid_o), 0);
        pop_one();
        chk("pop_empty_level", 32'(fifo_level_o), 0);
        chk("ovf_sticky", 32'(overflow_o), 1);

        tx_word  = 24'h3C5A96;
        enable_i = 1;
        wait_cs(0, "dis_cs_fall");
        @(negedge wb_clk_i);
        wait_rises(10, "dis_bit10");
        enable_i = 0;
        wait_cs(1, "dis_cs_rise");
        cycles(2);
        chk("dis_rises", rises, SB);
        chk("dis_data", 32'(sample_data_o), 32'h3C5A96);
        chk("dis_level", 32'(fifo_level_o), 1);
        falls = cs_falls;
        cycles(1000);
        chk("dis_no_retrigger", cs_falls, falls);
        chk("dis_busy", 32'(busy_o), 0);

        tx_word  = 24'h123456;
        enable_i = 1;
        wait_cs(0, "rst_cs_fall");
        @(negedge wb_clk_i);
        wait_rises(5, "rst_bit5");
        #2;
        wb_rst_ni = 0;
        enable_i  = 0;
        #1;
        chk("async_cs", 32'(adc_cs_no), 1);
        chk("async_sclk", 32'(adc_sclk_o), 0);
        chk("async_level", 32'(fifo_level_o), 0);
        chk("async_valid", 32'(sample_valid_o), 0);
        chk("async_ovf", 32'(overflow_o), 0);
        chk("async_ovf_count", 32'(ovf_count_o), 0);
        cycles(2);
        wb_rst_ni = 1;
        cycles(3);
        chk("post_rst_busy", 32'(busy_o), 0);
        chk("post_rst_cs", 32'(adc_cs_no), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
